// File: rtl/registrador_operandos.sv
// Operand/result register stage: captures ALU operands A and B from a shared bus on
// load-button rising edges and latches the ALU result on request. Optional macro: ACUMULADOR_EN.
module registrador_operandos #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dado_in,
  input  logic             carregar,
  input  logic             limpar,
  input  logic [WIDTH-1:0] resultado_in,
  input  logic             salvar_res,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] resultado,
  output logic             pronto,
  output logic             res_valido,
  output logic [1:0]       estado
);

  typedef enum logic [1:0] {
    ESPERA_A = 2'b00,
    ESPERA_B = 2'b01,
    PRONTO   = 2'b10,
    INVALIDO = 2'b11
  } estado_t;

  estado_t          r_estado;
  estado_t          w_estado_nxt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_resultado;
  logic             r_res_valido;
  logic             r_carregar_ant;
  logic [WIDTH-1:0] w_op_a_nxt;
  logic [WIDTH-1:0] w_op_b_nxt;
  logic [WIDTH-1:0] w_resultado_nxt;
  logic             w_res_valido_nxt;
  logic             w_pulso;

  // One pulse per press; the previous level is tracked even during limpar
  assign w_pulso = carregar & ~r_carregar_ant;

  // State and data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado       <= ESPERA_A;
      r_op_a         <= '0;
      r_op_b         <= '0;
      r_resultado    <= '0;
      r_res_valido   <= 1'b0;
      r_carregar_ant <= 1'b0;
    end else begin
      r_estado       <= w_estado_nxt;
      r_op_a         <= w_op_a_nxt;
      r_op_b         <= w_op_b_nxt;
      r_resultado    <= w_resultado_nxt;
      r_res_valido   <= w_res_valido_nxt;
      r_carregar_ant <= carregar;
    end
  end

  // Next-state and load/hold selection; priority limpar > pulso > salvar_res
  always_comb begin
    w_estado_nxt     = r_estado;
    w_op_a_nxt       = r_op_a;
    w_op_b_nxt       = r_op_b;
    w_resultado_nxt  = r_resultado;
    w_res_valido_nxt = r_res_valido;
    if (limpar) begin
      w_estado_nxt     = ESPERA_A;
      w_op_a_nxt       = '0;
      w_op_b_nxt       = '0;
      w_resultado_nxt  = '0;
      w_res_valido_nxt = 1'b0;
    end else begin
      case (r_estado)
        ESPERA_A: begin
          if (w_pulso) begin
            w_op_a_nxt   = dado_in;
            w_estado_nxt = ESPERA_B;
          end
        end
        ESPERA_B: begin
          if (w_pulso) begin
            w_op_b_nxt   = dado_in;
            w_estado_nxt = PRONTO;
          end
        end
        PRONTO: begin
          if (w_pulso) begin
            w_op_a_nxt       = dado_in;
            w_op_b_nxt       = '0;
            w_res_valido_nxt = 1'b0;
            w_estado_nxt     = ESPERA_B;
          end else if (salvar_res) begin
            w_resultado_nxt  = resultado_in;
            w_res_valido_nxt = 1'b1;
`ifdef ACUMULADOR_EN
            // Result becomes the next operand A so only B needs loading
            w_op_a_nxt       = resultado_in;
            w_op_b_nxt       = '0;
            w_estado_nxt     = ESPERA_B;
`endif
          end
        end
        default: begin
          w_estado_nxt     = ESPERA_A;
          w_op_a_nxt       = '0;
          w_op_b_nxt       = '0;
          w_resultado_nxt  = '0;
          w_res_valido_nxt = 1'b0;
        end
      endcase
    end
  end

  assign op_a       = r_op_a;
  assign op_b       = r_op_b;
  assign resultado  = r_resultado;
  assign res_valido = r_res_valido;
  assign estado     = r_estado;
  assign pronto     = (r_estado == PRONTO);

endmodule

// File: doc/registrador_operandos.md
Name: registrador_operandos

Overview:
- Operand/result storage stage directly downstream of the 2:1 hold/load multiplexers in the register path.
- Captures ALU operand A, then operand B, from a shared 8-bit data bus, each on a load-button rising edge.
- Presents both operands to the ALU with a ready flag, then latches the ALU result on request.
- Each register has load-or-hold semantics: the register keeps its value unless its load condition is true in that cycle.

Parameters:
- WIDTH, 8, data width of the bus, operands and result.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- dado_in  input  WIDTH  shared data bus (switches) for operand capture
- carregar  input  1  load button, level signal, already debounced; rising edge is detected internally
- limpar  input  1  synchronous clear of all state
- resultado_in  input  WIDTH  ALU result
- salvar_res  input  1  result capture request, sampled every cycle
- op_a  output  WIDTH  registered operand A
- op_b  output  WIDTH  registered operand B
- resultado  output  WIDTH  registered result
- pronto  output  1  high when both operands are valid (state PRONTO)
- res_valido  output  1  result register holds a result from the current operand pair
- estado  output  2  FSM state: 00 ESPERA_A, 01 ESPERA_B, 10 PRONTO

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: op_a, op_b and resultado = 0; pronto = 0; res_valido = 0; estado = ESPERA_A; internal carregar_ant = 0.
- Edge detect: carregar_ant is a register of carregar. pulso = carregar & ~carregar_ant, combinational.
  - Holding carregar high produces exactly one pulso.
  - carregar_ant updates every cycle, including while limpar is asserted. It is cleared only by rst.
- Latency: a register captures at the clock edge ending the first cycle where carregar = 1. The new value is visible in the next cycle.
- Priority within a cycle: rst > limpar > pulso > salvar_res.
- limpar: same effect as reset, except carregar_ant.
- FSM transitions:
  - ESPERA_A + pulso: op_a <= dado_in; go to ESPERA_B.
  - ESPERA_B + pulso: op_b <= dado_in; go to PRONTO.
  - PRONTO + pulso: starts a new pair. op_a <= dado_in; op_b <= 0; res_valido <= 0; go to ESPERA_B. resultado holds its old value.
  - PRONTO + salvar_res (no pulso): resultado <= resultado_in; res_valido <= 1; stay in PRONTO.
  - Repeated salvar_res in PRONTO overwrites resultado each time.
  - salvar_res outside PRONTO: ignored, no state change.
  - pulso and salvar_res in the same cycle in PRONTO: pulso wins and the result is discarded.
  - Illegal estado 11: next cycle goes to ESPERA_A with all registers cleared.
- Outputs:
  - pronto = (estado == PRONTO), decoded from registered state, so glitch-free.
  - res_valido is a register.
- Widths: no arithmetic; all data paths are exactly WIDTH bits with no truncation.

Optional Feature:
- Macro: ACUMULADOR_EN.
- Defined: salvar_res in PRONTO (no pulso, no limpar) does the following in the same edge:
  - resultado <= resultado_in; res_valido <= 1;
  - op_a <= resultado_in; op_b <= 0;
  - estado <= ESPERA_B.
  - This chains operations: the next pulso loads only B.
  - Behaviour with pulso in the same cycle is unchanged: pulso wins.
- Not defined: behaviour exactly as in Behaviour; no feedback path is synthesized.

Test Plan:
- Reset then load A: rst 1 cycle; dado_in=0x3C with carregar held 5 cycles -> op_a=0x3C one cycle after the first high cycle; estado=01; exactly one capture.
- Full pair plus result: A=0x12, then release carregar, then B=0xF0; then resultado_in=0x02 with salvar_res=1 -> op_b=0xF0, pronto=1, resultado=0x02, res_valido=1, estado=10.
- Restart from PRONTO: after the previous case, pulse with dado_in=0x55 -> op_a=0x55, op_b=0, res_valido=0, resultado stays 0x02, estado=01.
- Simultaneous events: in PRONTO, pulso with dado_in=0xAA and salvar_res=1 with resultado_in=0x77 in the same cycle -> op_a=0xAA, resultado unchanged, estado=01. Then limpar with pulso -> all zero, estado=00.
- Ignored request plus mid-operation reset: salvar_res in ESPERA_B -> no change. rst while carregar is held high -> all zero. carregar stays high after rst -> one pulso, because carregar_ant=0 after rst.
- ACUMULADOR_EN build: A=0x05, B=0x03, salvar_res with resultado_in=0x08 -> op_a=0x08, op_b=0, res_valido=1, estado=01. Without the macro -> op_a=0x05, estado=10.
